data_memory_sized: RTL and testbench

- Next-generation byte-addressable data memory for the single-cycle/multicycle RV64 datapath.
- Generalised in depth and access size (byte/half/word/double) with sign/zero extension on loads.
- Uses a valid/ready request handshake, a programmable wait-state counter and a one-cycle response pulse, so the core can be tested against slow memory.
- Sits between the ALU address output and the write-back mux.

---
 rtl/data_memory_sized.sv | 179 +++++++++++++++++
 tb/tb_data_memory_sized.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
`default_nettype none
// data_memory_sized: byte-addressable RV64 data memory with valid/ready request, wait states and a one-cycle response.
// Optional misaligned-access trap: define DATA_MEMORY_MISALIGN_TRAP_EN. Rev 1.0
module data_memory_sized #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int MEM_W = DEPTH_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [MEM_W-1:0] init_mem();
    logic [MEM_W-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH_BYTES; i++) v[i*8 +: 8] = 8'(i % 256);
    return v;
  endfunction

  // Flat packed storage so the power-up pattern can be given as a declaration value.
  logic [MEM_W-1:0] mem = init_mem();

  state_t            state;
  state_t            next_state;
  logic [3:0]        wait_cnt;
  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_unsigned;
  logic [ADDR_W-1:0] cap_addr;
  logic [63:0]       cap_wdata;

  logic              accept;
  logic              commit;
  logic              src_we;
  logic [1:0]        src_size;
  logic              src_unsigned;
  logic [ADDR_W-1:0] src_addr;
  logic [63:0]       src_wdata;
  logic [3:0]        nbytes;
  logic [ADDR_W:0]   last_addr;
  logic              range_fault;
  logic              fault;
  logic [IDX_W-1:0]  byte_idx [8];
  logic [63:0]       raw_data;
  logic              sign_bit;
  logic [63:0]       load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (accept)
        wait_cnt <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      else if (state == ST_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: begin
        rsp_valid  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign accept = (state == ST_IDLE) && req_valid;
  assign commit = (next_state == ST_RESP) && (state != ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we       <= 1'b0;
      cap_size     <= 2'd0;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
    end else if (accept) begin
      cap_we       <= req_we;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

  // With no wait states the commit edge is the accept edge, so use the live request.
  assign src_we       = (state == ST_IDLE) ? req_we       : cap_we;
  assign src_size     = (state == ST_IDLE) ? req_size     : cap_size;
  assign src_unsigned = (state == ST_IDLE) ? req_unsigned : cap_unsigned;
  assign src_addr     = (state == ST_IDLE) ? req_addr     : cap_addr;
  assign src_wdata    = (state == ST_IDLE) ? req_wdata    : cap_wdata;

  assign nbytes      = 4'd1 << src_size;
  assign last_addr   = {1'b0, src_addr} + (ADDR_W+1)'(nbytes - 4'd1);
  assign range_fault = last_addr >= (ADDR_W+1)'(DEPTH_BYTES);

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (src_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
  assign fault      = range_fault | misaligned;
`else
  assign fault = range_fault;
`endif

  always_comb begin
    for (int k = 0; k < 8; k++) byte_idx[k] = src_addr[IDX_W-1:0] + IDX_W'(k);
  end

  always_comb begin
    raw_data = '0;
    for (int k = 0; k < 8; k++)
      if (4'(k) < nbytes) raw_data[k*8 +: 8] = mem[{byte_idx[k], 3'b000} +: 8];
    case (src_size)
      2'd0:    sign_bit = raw_data[7];
      2'd1:    sign_bit = raw_data[15];
      2'd2:    sign_bit = raw_data[31];
      default: sign_bit = raw_data[63];
    endcase
    load_data = raw_data;
    for (int k = 0; k < 8; k++)
      if (4'(k) >= nbytes) load_data[k*8 +: 8] = {8{sign_bit & ~src_unsigned}};
  end

  // Reset only holds the array, so an in-flight store is dropped rather than cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= mem;
    end else if (commit && src_we && !fault) begin
      for (int k = 0; k < 8; k++)
        if (4'(k) < nbytes) mem[{byte_idx[k], 3'b000} +: 8] <= src_wdata[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (fault || src_we) ? 64'd0 : load_data;
      rsp_err   <= fault;
    end else begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// tb_data_memory_sized: scoreboard bench for data_memory_sized with default parameters.
module tb_data_memory_sized;

  localparam int WAITC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [256];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  data_memory_sized #(.DEPTH_BYTES(256), .ADDR_W(64), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd, output exp_t e);
    int n;
    logic [64:0] last;
    n    = 1 << sz;
    last = {1'b0, addr} + 65'(n - 1);
    e.rd  = 64'd0;
    e.err = (last >= 65'd256);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    if ((addr % 64'(n)) != 64'd0) e.err = 1'b1;
`endif
    if (!e.err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mem_m[addr[7:0] + 8'(k)] = wd[k*8 +: 8];
      end else begin
        for (int k = 0; k < n; k++) e.rd[k*8 +: 8] = mem_m[addr[7:0] + 8'(k)];
        if (!uns && e.rd[8*n-1])
          for (int b = 8*n; b < 64; b++) e.rd[b] = 1'b1;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input bit push, output realtime t_acc);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    if (push) begin
      model(we, sz, uns, addr, wd, e);
      sb.push_back(e);
    end
    @(posedge clk);
    t_acc = $realtime;
    #1;
    // Scramble inputs after accept; the DUT must have captured them.
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
  endtask

  task automatic collect(output logic [63:0] d, output logic e, output int lat,
                         output bit ready_bad);
    lat = -1; ready_bad = 0; d = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req_ready) ready_bad = 1;
      if (rsp_valid) begin
        d = rsp_rdata; e = rsp_err; lat = i;
        break;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wd,
                     output logic [63:0] d, output logic e, output int lat,
                     output bit ready_bad, output exp_t ex);
    realtime t;
    issue(we, sz, uns, addr, wd, 1'b1, t);
    collect(d, e, lat, ready_bad);
    ex = (sb.size() > 0) ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_after_reset got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_load_basic();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex;
    txn(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (lat !== WAITC + 1) begin
      n_errors++; $display("FAIL ld8_latency got %0d want %0d", lat, WAITC + 1);
    end
    n_checks++;
    if (d !== ex.rd || e !== ex.err) begin
      n_errors++; $display("FAIL ld8_data got %h/%b want %h/%b", d, e, ex.rd, ex.err);
    end
    n_checks++;
    if (d !== 64'h0F0E0D0C0B0A0908) begin
      n_errors++; $display("FAIL ld8_value got %h want 0f0e0d0c0b0a0908", d);
    end
  endtask

  task automatic test_load_ext();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex;
    logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        un  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] ad  [5] = '{64'h80, 64'h80, 64'hFE, 64'hFE, 64'hFC};
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, sz[i], un[i], ad[i], 64'd0, d, e, lat, rb, ex);
      n_checks++;
      if (d !== ex.rd || e !== ex.err || lat !== WAITC + 1) begin
        n_errors++;
        $display("FAIL load_ext[%0d] got %h/%b lat %0d want %h/%b lat %0d",
                 i, d, e, lat, ex.rd, ex.err, WAITC + 1);
      end
    end
  endtask

  task automatic test_store();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex;
    txn(1'b1, 2'd2, 1'b0, 64'd16, 64'h12345678DEADBEEF, d, e, lat, rb, ex);
    n_checks++;
    if (d !== 64'd0 || e !== 1'b0 || rb) begin
      n_errors++; $display("FAIL sw16_rsp got %h/%b ready_seen=%b want 0/0/0", d, e, rb);
    end
    txn(1'b0, 2'd3, 1'b0, 64'd16, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (d !== 64'h17161514DEADBEEF || d !== ex.rd || rb) begin
      n_errors++; $display("FAIL ld16_after_sw got %h ready_seen=%b want %h", d, rb, ex.rd);
    end
    txn(1'b1, 2'd0, 1'b0, 64'h41, 64'hFFFF_FFFF_FFFF_FFA5, d, e, lat, rb, ex);
    txn(1'b0, 2'd2, 1'b1, 64'h40, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (d !== ex.rd || d !== 64'h0000_0000_4342A540) begin
      n_errors++; $display("FAIL sb_then_lwu got %h want %h", d, ex.rd);
    end
  endtask

  task automatic test_range();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex;
    txn(1'b0, 2'd3, 1'b0, 64'd252, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (e !== 1'b1 || d !== 64'd0 || lat !== WAITC + 1) begin
      n_errors++; $display("FAIL ld252_range got %h/%b lat %0d want 0/1", d, e, lat);
    end
    txn(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hAAAA_AAAA_AAAA_AAAA, d, e, lat, rb, ex);
    n_checks++;
    if (e !== 1'b1 || d !== 64'd0) begin
      n_errors++; $display("FAIL sd_overflow got %h/%b want 0/1", d, e);
    end
    txn(1'b0, 2'd3, 1'b0, 64'd248, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (e !== 1'b0 || d !== ex.rd) begin
      n_errors++; $display("FAIL ld248_edge got %h/%b want %h/0", d, e, ex.rd);
    end
    txn(1'b0, 2'd0, 1'b1, 64'h100, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (e !== 1'b1 || d !== 64'd0) begin
      n_errors++; $display("FAIL lbu256_range got %h/%b want 0/1", d, e);
    end
    txn(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (d !== ex.rd) begin
      n_errors++; $display("FAIL mem_after_fault got %h want %h", d, ex.rd);
    end
  endtask

  task automatic test_misalign();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex;
    txn(1'b0, 2'd3, 1'b0, 64'd3, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (d !== ex.rd || e !== ex.err || lat !== WAITC + 1) begin
      n_errors++; $display("FAIL ld3_misalign got %h/%b lat %0d want %h/%b", d, e, lat, ex.rd, ex.err);
    end
    txn(1'b1, 2'd1, 1'b0, 64'h21, 64'h0000_0000_0000_CAFE, d, e, lat, rb, ex);
    txn(1'b0, 2'd2, 1'b1, 64'h20, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (d !== ex.rd || e !== ex.err) begin
      n_errors++; $display("FAIL sh_misalign_mem got %h/%b want %h/%b", d, e, ex.rd, ex.err);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex; realtime ta, tb;
    issue(1'b0, 2'd1, 1'b0, 64'h90, 64'd0, 1'b1, ta);
    collect(d, e, lat, rb);
    ex = (sb.size() > 0) ? sb.pop_front() : '0;
    n_checks++;
    if (d !== ex.rd) begin
      n_errors++; $display("FAIL b2b_first got %h want %h", d, ex.rd);
    end
    issue(1'b0, 2'd0, 1'b0, 64'hF0, 64'd0, 1'b1, tb);
    n_checks++;
    if (int'((tb - ta) / 10.0) !== WAITC + 2) begin
      n_errors++; $display("FAIL b2b_spacing got %0d cycles want %0d", int'((tb - ta) / 10.0), WAITC + 2);
    end
    collect(d, e, lat, rb);
    ex = (sb.size() > 0) ? sb.pop_front() : '0;
    n_checks++;
    if (d !== ex.rd || lat !== WAITC + 1) begin
      n_errors++; $display("FAIL b2b_second got %h lat %0d want %h", d, lat, ex.rd);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++; $display("FAIL rsp_pulse_width got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic e; int lat; bit rb; exp_t ex; realtime t; bit seen;
    issue(1'b1, 2'd3, 1'b0, 64'd0, 64'h1111_1111_1111_1111, 1'b0, t);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_async got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL mid_reset_no_rsp got rsp_valid=1 want 0");
    end
    txn(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, d, e, lat, rb, ex);
    n_checks++;
    if (d !== 64'h0706050403020100 || d !== ex.rd) begin
      n_errors++; $display("FAIL mid_reset_mem got %h want 0706050403020100", d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_load_basic();
    test_load_ext();
    test_store();
    test_range();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
